// File: rtl/axi_slave_ext.sv
// AXI4 slave RAM: FIXED/INCR/WRAP bursts, base/size decode window (DECERR), SLVERR on protocol faults.
// One write outstanding at a time; first R beat the cycle after AR, then one beat per cycle while rready holds.
module axi_slave_ext #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 16,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter int          ID_WIDTH   = 8,
  parameter int          MEM_WORDS  = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int                  LANE_W   = $clog2(STRB_WIDTH);
  localparam int                  IDX_W    = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE_LO = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   SPAN    = (ADDR_WIDTH + 1)'(MEM_WORDS * STRB_WIDTH);
  localparam logic [2:0]          MAX_SIZE = 3'(LANE_W);
  localparam logic [1:0]          RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_BURST}        rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_LO;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_LO;
    return off[LANE_W +: IDX_W];
  endfunction

  function automatic logic [2:0] clamp_size(input logic [2:0] sz);
    return (sz > MAX_SIZE) ? MAX_SIZE : sz;
  endfunction

  function automatic logic burst_err(input logic [1:0] bt, input logic [7:0] len);
    return (bt == 2'b11) ||
           (bt == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] sz,
                                                      input logic [7:0] len,
                                                      input logic [1:0] bt);
    logic [ADDR_WIDTH-1:0] bytes, total, lower, nxt;
    bytes = ADDR_WIDTH'(1) << sz;
    total = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    lower = a & ~(total - ADDR_WIDTH'(1));
    nxt   = a + bytes;
    case (bt)
      2'b01:   nxt = (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
      2'b10:   if (nxt == lower + total) nxt = lower;
      default: nxt = a;
    endcase
    return nxt;
  endfunction

  // ---------------- write channel ----------------
  wstate_t               w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_dec, w_slv;

  logic             w_hs, w_last_beat, w_bad_last, w_in, w_en;
  logic [IDX_W-1:0] w_idx;

  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_bad_last  = (s_axi_wlast != w_last_beat);
  assign w_in        = in_win(w_addr);
  assign w_idx       = word_idx(w_addr);
  // An offending beat is itself dropped, not only the beats after it.
  assign w_en        = !rst && w_hs && w_in && !w_slv && !w_bad_last;

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_dec         <= 1'b0;
      w_slv         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= clamp_size(s_axi_awsize);
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_dec         <= 1'b0;
            w_slv         <= burst_err(s_axi_awburst, s_axi_awlen);
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_dec  <= w_dec | !w_in;
            w_slv  <= w_slv | w_bad_last;
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_dec || !w_in)       ? RESP_DECERR :
                              (w_slv || w_bad_last)  ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  // In IDLE the first beat is fetched straight from the AR channel so it can register on the handshake edge.
  logic [ADDR_WIDTH-1:0] r_src_addr;
  logic                  r_src_err, r_src_in;
  logic [DATA_WIDTH-1:0] r_word, beat_data;
  logic [1:0]            beat_resp;

  assign r_src_addr = (r_state == R_IDLE) ? s_axi_araddr : r_addr;
  assign r_src_err  = (r_state == R_IDLE) ? burst_err(s_axi_arburst, s_axi_arlen) : r_err;
  assign r_src_in   = in_win(r_src_addr);
  assign r_word     = mem[word_idx(r_src_addr)];
  assign beat_data  = (!r_src_in || r_src_err) ? '0 : r_word;
  assign beat_resp  = !r_src_in ? RESP_DECERR : r_src_err ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_len         <= s_axi_arlen;
            r_size        <= clamp_size(s_axi_arsize);
            r_burst       <= s_axi_arburst;
            r_err         <= r_src_err;
            r_addr        <= next_addr(s_axi_araddr, clamp_size(s_axi_arsize), s_axi_arlen, s_axi_arburst);
            r_cnt         <= 8'd1;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rdata   <= beat_data;
            s_axi_rresp   <= beat_resp;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_state       <= R_BURST;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_BURST: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= beat_data;
              s_axi_rresp <= beat_resp;
              s_axi_rlast <= (r_cnt == r_len);
              r_addr      <= next_addr(r_addr, r_size, r_len, r_burst);
              r_cnt       <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: tb/tb_axi_slave_ext.sv
// Bench for axi_slave_ext: directed scenarios then random bursts checked against a behavioural memory model.
module tb_axi_slave_ext;

  localparam int MW   = 16;
  localparam int BASE = 'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awid = '0, arid = '0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;

  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast;
  logic [7:0]  s_axi_bid, s_axi_rid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;

  axi_slave_ext #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awvalid(awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arvalid(arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] model_mem [MW];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rq_data [256];
  logic [1:0]  rq_resp [256];
  logic        rq_last [256];
  logic [7:0]  rq_id   [256];
  logic [1:0]  last_bresp;
  logic [7:0]  last_bid;
  int          wrap_lens [4] = '{1, 3, 7, 15};
  logic [3:0]  stall_ptn = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------- behavioural reference ----------
  function automatic logic m_in_win(input logic [15:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + MW * 4);
  endfunction

  function automatic int m_idx(input logic [15:0] a);
    return (int'(a) - BASE) / 4;
  endfunction

  function automatic logic m_burst_err(input logic [1:0] bt, input logic [7:0] len);
    return (bt == 2'b11) || (bt == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Address of beat i computed directly from the start address, not by stepping.
  function automatic logic [15:0] m_beat_addr(input logic [15:0] start, input int i, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] bt);
    int s, bytes, total, lower;
    s = int'(start);
    bytes = 1 << ((size > 3'd2) ? 2 : int'(size));
    case (bt)
      2'b01: return (i == 0) ? start : 16'((s / bytes) * bytes + i * bytes);
      2'b10: begin
        total = bytes * (int'(len) + 1);
        lower = s & ~(total - 1);
        return 16'(lower + ((s - lower) + i * bytes) % total);
      end
      default: return start;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, s_axi_awready, 0);
    check({tag, "_arready"}, s_axi_arready, 0);
    check({tag, "_wready"},  s_axi_wready, 0);
    check({tag, "_bvalid"},  s_axi_bvalid, 0);
    check({tag, "_rvalid"},  s_axi_rvalid, 0);
    check({tag, "_rlast"},   s_axi_rlast, 0);
    check({tag, "_bid"},     s_axi_bid, 0);
    check({tag, "_rid"},     s_axi_rid, 0);
    check({tag, "_rdata"},   s_axi_rdata, 0);
    check({tag, "_bresp"},   s_axi_bresp, 0);
    check({tag, "_rresp"},   s_axi_rresp, 0);
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt, input int wlast_at, input int bdelay);
    int n, err_from;
    logic dec, berr;
    logic [15:0] a;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    check("aw_handshake", s_axi_awready, 1);
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
      n = 0; @(negedge clk);
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      if (!s_axi_wready) begin check("w_handshake", s_axi_wready, 1); break; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0; @(negedge clk);
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    check("b_valid", s_axi_bvalid, 1);
    last_bresp = s_axi_bresp; last_bid = s_axi_bid;
    if (bdelay > 0) begin
      repeat (bdelay) @(negedge clk);
      check("b_hold_valid", s_axi_bvalid, 1);
      check("b_hold_awready", s_axi_awready, 0);
      check("b_hold_bid", s_axi_bid, last_bid);
      check("b_hold_bresp", s_axi_bresp, last_bresp);
    end
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    check("b_released", s_axi_bvalid, 0);
    check("aw_returns", s_axi_awready, 1);
    // reference update and expected response
    berr = m_burst_err(bt, len);
    err_from = (wlast_at >= 0 && wlast_at != int'(len)) ? wlast_at : 256;
    dec = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = m_beat_addr(addr, i, size, len, bt);
      if (!m_in_win(a)) dec = 1'b1;
      else if (!berr && i < err_from)
        for (int b = 0; b < 4; b++) if (ws[i][b]) model_mem[m_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
    end
    check("bresp", last_bresp, dec ? 2'b11 : (berr || err_from < 256) ? 2'b10 : 2'b00);
    check("bid", last_bid, id);
  endtask

  // mode 0: rready always high, 1: repeating 1,0,0,1, 2: random
  task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] bt, input int mode);
    int n, got, cyc;
    logic stalled;
    logic [31:0] s_data; logic [1:0] s_resp; logic s_last; logic [7:0] s_id;
    logic [15:0] a; logic [1:0] er;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = bt; arvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    check("ar_handshake", s_axi_arready, 1);
    @(posedge clk); #1; arvalid = 1'b0;
    got = 0; cyc = 0; stalled = 1'b0;
    s_data = '0; s_resp = '0; s_last = 1'b0; s_id = '0;
    while (got <= int'(len) && cyc < 600) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? stall_ptn[3 - (cyc % 4)] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        check("stall_rvalid", s_axi_rvalid, 1);
        check("stall_rdata", s_axi_rdata, s_data);
        check("stall_rresp", s_axi_rresp, s_resp);
        check("stall_rlast", s_axi_rlast, s_last);
        check("stall_rid", s_axi_rid, s_id);
      end
      stalled = 1'b0;
      if (s_axi_rvalid) begin
        if (rready) begin
          rq_data[got] = s_axi_rdata; rq_resp[got] = s_axi_rresp;
          rq_last[got] = s_axi_rlast; rq_id[got] = s_axi_rid;
          got++;
        end else begin
          stalled = 1'b1;
          s_data = s_axi_rdata; s_resp = s_axi_rresp; s_last = s_axi_rlast; s_id = s_axi_rid;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    rready = 1'b0;
    check("r_beat_count", got, int'(len) + 1);
    @(negedge clk);
    check("r_no_extra_beat", s_axi_rvalid, 0);
    check("ar_returns", s_axi_arready, 1);
    for (int i = 0; i < got; i++) begin
      a  = m_beat_addr(addr, i, size, len, bt);
      er = !m_in_win(a) ? 2'b11 : m_burst_err(bt, len) ? 2'b10 : 2'b00;
      check($sformatf("rresp[%0d]", i), rq_resp[i], er);
      check($sformatf("rdata[%0d]", i), rq_data[i], (er == 2'b00) ? model_mem[m_idx(a)] : 32'h0);
      check($sformatf("rlast[%0d]", i), rq_last[i], i == int'(len));
      check($sformatf("rid[%0d]", i), rq_id[i], id);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, got;
    logic [2:0] sz;
    logic [1:0] bt;
    logic [7:0] ln;
    logic [15:0] ad;
    foreach (model_mem[i]) model_mem[i] = '0;

    // reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("release_awready", s_axi_awready, 1);
    check("release_arready", s_axi_arready, 1);

    // INCR write 1..4 then read back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(8'h11, 16'h1010, 8'd3, 3'd2, 2'b01, -1, 0);
    check("incr_bresp_okay", last_bresp, 2'b00);
    axi_read(8'h22, 16'h1010, 8'd3, 3'd2, 2'b01, 0);
    check("incr_beat3", rq_data[3], 32'h4);

    // WRAP read after preloading A..D
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
    axi_write(8'h33, 16'h1030, 8'd3, 3'd2, 2'b01, -1, 0);
    axi_read(8'h44, 16'h1038, 8'd3, 3'd2, 2'b10, 0);
    check("wrap_b0", rq_data[0], 32'hC);
    check("wrap_b1", rq_data[1], 32'hD);
    check("wrap_b2", rq_data[2], 32'hA);
    check("wrap_b3", rq_data[3], 32'hB);

    // burst straddling the top of the window
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * 32'(i + 1); ws[i] = 4'hF; end
    axi_write(8'h55, 16'h1038, 8'd3, 3'd2, 2'b01, -1, 0);
    check("straddle_decerr", last_bresp, 2'b11);
    axi_read(8'h56, 16'h1038, 8'd3, 3'd2, 2'b01, 0);
    axi_read(8'h57, 16'h1040, 8'd0, 3'd2, 2'b01, 0);
    check("oow_rdata", rq_data[0], 32'h0);
    check("oow_rresp", rq_resp[0], 2'b11);

    // protocol errors leave RAM untouched
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hDEAD0000 | 32'(i); ws[i] = 4'hF; end
    axi_write(8'h60, 16'h1000, 8'd2, 3'd2, 2'b10, -1, 0);
    check("wrap_len2_slverr", last_bresp, 2'b10);
    axi_write(8'h61, 16'h1010, 8'd3, 3'd2, 2'b01, 0, 0);
    check("early_wlast_slverr", last_bresp, 2'b10);
    axi_read(8'h62, 16'h1010, 8'd3, 3'd2, 2'b01, 0);
    check("ram_unchanged", rq_data[0], 32'h1);
    axi_read(8'h63, 16'h1000, 8'd2, 3'd2, 2'b10, 0);
    axi_read(8'h64, 16'h1004, 8'd1, 3'd2, 2'b11, 0);

    // backpressure on R and B
    axi_read(8'h70, 16'h1010, 8'd3, 3'd2, 2'b01, 1);
    axi_write(8'h71, 16'h1020, 8'd1, 3'd2, 2'b01, -1, 5);

    // reset pulsed while beat 2 of a 4-beat read is presented
    @(posedge clk); #1;
    arid = 8'h5A; araddr = 16'h1010; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    n = 0; @(negedge clk);
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    check("rstmid_ar", s_axi_arready, 1);
    @(posedge clk); #1; arvalid = 1'b0; rready = 1'b1;
    got = 0; n = 0;
    while (got < 2 && n < 20) begin
      @(negedge clk); if (s_axi_rvalid) got++;
      @(posedge clk); #1; n++;
    end
    check("rstmid_beats", got, 2);
    rst = 1'b1; rready = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all_zero("rstmid");
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstmid_awready", s_axi_awready, 1);
    check("rstmid_arready", s_axi_arready, 1);
    axi_read(8'h5B, 16'h1010, 8'd3, 3'd2, 2'b01, 0);

    // random bursts
    for (int it = 0; it < 24; it++) begin
      bt = 2'($urandom_range(0, 2));
      sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      ln = (bt == 2'b10) ? 8'(wrap_lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 7));
      ad = 16'((16'h0FF0 + $urandom_range(0, 96)) & ~((1 << ((sz > 3'd2) ? 2 : int'(sz))) - 1));
      for (int i = 0; i <= int'(ln); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      axi_write(8'($urandom), ad, ln, sz, bt, -1, 0);
      axi_read(8'($urandom), ad, ln, sz, bt, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_slave_ext.md
Name: axi_slave_ext

Overview:
AXI4 slave RAM that supersedes the single-range, partial-burst RAM slave. It adds full WRAP burst address generation and a memory depth set independently of the address width. It decodes a base/size address window: out-of-window beats return DECERR, and protocol violations return SLVERR. It sits at an interconnect leaf as a verification and target memory in the AXI UVM environment.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8 * power of two)
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, byte-lane count
ID_WIDTH, 8, AXI ID width
MEM_WORDS, 1024, RAM depth in DATA_WIDTH words (power of two)
BASE_ADDR, 0, byte address of word 0; window = [BASE_ADDR, BASE_ADDR + MEM_WORDS*STRB_WIDTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
s_axi_awid / s_axi_arid  input  ID_WIDTH  write / read transaction ID
s_axi_awaddr / s_axi_araddr  input  ADDR_WIDTH  start byte address
s_axi_awlen / s_axi_arlen  input  8  beats minus one
s_axi_awsize / s_axi_arsize  input  3  log2 bytes per beat
s_axi_awburst / s_axi_arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awlock, awcache, awprot, arlock, arcache, arprot  input  1/4/3  accepted, ignored
s_axi_awvalid / s_axi_arvalid  input  1  address valid
s_axi_awready / s_axi_arready  output  1  address ready
s_axi_wdata  input  DATA_WIDTH  write data
s_axi_wstrb  input  STRB_WIDTH  byte enables
s_axi_wlast, s_axi_wvalid  input  1  last beat, data valid
s_axi_wready  output  1  write data ready
s_axi_bid  output  ID_WIDTH  response ID
s_axi_bresp  output  2  write response
s_axi_bvalid  output  1  response valid
s_axi_bready  input  1  response ready
s_axi_rid  output  ID_WIDTH  read ID
s_axi_rdata  output  DATA_WIDTH  read data
s_axi_rresp  output  2  per-beat read response
s_axi_rlast, s_axi_rvalid  output  1  last beat, data valid
s_axi_rready  input  1  read data ready

Behaviour:
- Reset values: all ready/valid outputs 0; rlast 0; bid, rid, rdata, bresp, rresp all 0. awready and arready rise on the first cycle after rst deasserts. RAM contents are initialised to 0 at time zero and are preserved across rst. rst mid-burst abandons the burst with no response issued.
- Size is clamped to log2(STRB_WIDTH). Let bytes = 1<<size.
- Address generation:
  - FIXED: address is held for every beat.
  - INCR: next = aligned(addr, bytes) + bytes.
  - WRAP: total = bytes*(len+1) and lower = addr & ~(total-1). Next = addr + bytes; if next == lower + total, next = lower. Arithmetic is performed mod 2^ADDR_WIDTH.
- Decode: a beat is in window if BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*STRB_WIDTH. Word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH).
- Protocol errors (SLVERR):
  - burst = 11
  - WRAP with len not in {1, 3, 7, 15}
  - WLAST asserted before the final beat, or absent on the final beat
- Write FSM, states IDLE -> DATA -> RESP -> IDLE:
  - IDLE: awready = 1. On AW handshake, latch id/addr/len/size/burst, clear error flags, awready = 0, and assert wready next cycle.
  - DATA: wready = 1. Each W handshake writes the strobed lanes only if the beat is in window and there is no protocol error. The beat counter, not WLAST, terminates the burst. After the final handshake, wready = 0 and bvalid = 1 the next cycle.
  - RESP: bvalid and bid are held stable until bready. bresp = 11 DECERR if any beat was out of window; else 10 SLVERR if a protocol error occurred; else 00 OKAY. awready returns the cycle after the B handshake, so there is one write outstanding at a time.
- Read FSM, states IDLE -> BURST -> IDLE:
  - IDLE: arready = 1. On AR handshake, latch fields and set arready = 0.
  - BURST: the first rvalid appears the cycle after the AR handshake. rdata is registered. While rready is held high, one beat is issued per cycle.
  - rvalid, rdata, rid, rresp and rlast are held stable while rvalid && !rready.
  - Per beat: an out-of-window beat gives rdata 0 and rresp 11. A protocol-error burst gives rdata 0 and rresp 10 on every beat. Otherwise the beat gives RAM data and rresp 00.
  - rlast is 1 only on beat len. arready returns the cycle after the final R handshake.
- Read and write channels are independent. A read and a write to the same word in the same cycle returns the old data.

Test Plan:
- INCR write, awaddr 0x0010, len 3, size 2, data 1..4, wstrb F -> bresp 00. INCR read of the same -> 1, 2, 3, 4 with rlast on beat 3 and rresp 00.
- WRAP read, araddr 0x0038, len 3, size 2, after preloading 0x30..0x3C with A..D -> beat addresses 0x38, 0x3C, 0x30, 0x34, returning C, D, A, B.
- BASE_ADDR 0x1000, MEM_WORDS 16: INCR write at 0x1038, len 3 -> beats at 0x1038 and 0x103C written; beats at 0x1040 and 0x1044 dropped; bresp 11. Read of 0x1040 -> rdata 0, rresp 11.
- WRAP with len 2, or a write with WLAST on beat 1 of 4 -> bresp 10 and RAM unchanged.
- rready toggled 1,0,0,1 during a 4-beat read -> no beat lost or duplicated; outputs held stable while stalled. bready held low for 5 cycles -> bvalid held and awready stays 0.
- rst pulsed mid-burst on beat 2 of 4 -> all outputs return to 0, awready and arready are 1 the cycle after release, and previously written RAM data is intact.
